sobel_filter: RTL and testbench
===============================

SOBEL_FILTER -- requirements
Module: sobel_filter

Interface
REQ-001 Parameter LINE_WIDTH, default 640, gray pixels per line.
REQ-002 Parameter FRAME_HEIGHT, default 480, gray lines per frame.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 gray_pixel  input  12  unsigned grayscale sample from the Bayer-to-gray stage.
REQ-006 gray_pixel_valid  input  1  gray_pixel accepted on this rising edge.
REQ-007 sof  input  1  start of frame; qualified by gray_pixel_valid.
REQ-008 threshold  input  12  edge decision level; sampled with the compute stage.
REQ-009 sobel_pixel  output  12  saturated gradient magnitude.
REQ-010 sobel_valid  output  1  one-cycle strobe; sobel outputs valid.
REQ-011 sobel_edge  output  1  sobel_pixel >= threshold.
REQ-012 sobel_col  output  16  column of the output center pixel.
REQ-013 sobel_row  output  16  row of the output center pixel.

Function
REQ-014 Internal col/row counters SHALL advance only on accepted pixels (gray_pixel_valid=1); col wraps LINE_WIDTH-1 -> 0 with row+1; row wraps FRAME_HEIGHT-1 -> 0.
REQ-015 An accepted pixel with sof=1 SHALL be treated as (row 0, col 0) regardless of counter state; next accepted pixel is (0,1); sof without valid is ignored.
REQ-016 Two line buffers (12 x LINE_WIDTH each) SHALL supply rows r-1 and r-2 at the current column; they write only on accepted pixels.
REQ-017 A 3x3 window register SHALL shift on each accepted pixel; with current input at (r,c), window covers rows r-2..r, cols c-2..c, center (r-1,c-1).
REQ-018 Gx = (right column weighted 1,2,1) - (left column weighted 1,2,1); Gy = (bottom row weighted 1,2,1) - (top row weighted 1,2,1); both 15-bit signed minimum, computed without overflow.
REQ-019 Magnitude SHALL be |Gx|+|Gy| (16-bit unsigned), saturated to 4095 for sobel_pixel.
REQ-020 An output SHALL be produced only for accepted inputs with r>=2 and c>=2; each frame yields exactly (LINE_WIDTH-2)x(FRAME_HEIGHT-2) strobes; border centers produce none.
REQ-021 sobel_valid, sobel_pixel, sobel_edge, sobel_col=c-1, sobel_row=r-1 SHALL appear exactly 2 clocks after the accepting edge, all registered.
REQ-022 Pipeline after the window SHALL advance every clock; gaps in gray_pixel_valid SHALL not change values or latency, only strobe spacing.
REQ-023 Back-to-back valid input at full rate SHALL be sustained with no stall and no dropped output.
REQ-024 sobel_valid SHALL be 0 in every cycle not covered by REQ-020/021.

Reset
REQ-025 While rst=1: counters, window registers, pipeline valid and all outputs SHALL be 0 immediately (asynchronous).
REQ-026 Line buffer storage need not be reset; outputs are gated until two rows of the new frame are stored.
REQ-027 After reset release, first accepted pixel SHALL be (0,0) with or without sof.
REQ-028 Reset mid-frame SHALL discard in-flight results; no sobel_valid until r>=2,c>=2 of the restarted count.

Verification
REQ-029 Constant frame, all pixels 1234, threshold 1 -> every output sobel_pixel=0, sobel_edge=0, strobe count 638x478.
REQ-030 Vertical step, cols<320 = 0, cols>=320 = 1000, threshold 3000 -> centers col 319 and 320 give 4000, edge=1; all other centers 0.
REQ-031 Same step with 2000 -> centers col 319/320 saturate to 4095; horizontal step at row 240 with 1000 -> rows 239/240 give 4000.
REQ-032 Random gaps in gray_pixel_valid vs. full-rate run of same image -> identical output sequence (pixel, col, row), each 2 clocks after its accepting input.
REQ-033 sof asserted at counter (100,50) -> that pixel becomes (0,0); no strobes until input (2,2), first output row=1, col=1.
REQ-034 rst pulsed mid-frame at row 200 -> outputs 0 at once; after release, first strobe at input (2,2) with sobel_row=1, sobel_col=1.

Source files
------------

// File: rtl/sobel_filter.sv
// sobel_filter: streaming 3x3 Sobel edge detector for a 12-bit grayscale raster.
// Two line buffers feed a 3x3 window. A two-stage registered pipeline follows:
// stage 1 holds the gradient magnitude, and stage 2 holds the saturated pixel
// and the edge decision.
//
// Handshake: the input is valid-only. A pixel is consumed on every rising edge
// where gray_pixel_valid=1, and there is no backpressure. sobel_valid is a
// one-cycle strobe that marks the output fields; downstream logic must accept
// it whenever it is high.
module sobel_filter #(
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] gray_pixel,
  input  logic        gray_pixel_valid,
  input  logic        sof,
  input  logic [11:0] threshold,
  output logic [11:0] sobel_pixel,
  output logic        sobel_valid,
  output logic        sobel_edge,
  output logic [15:0] sobel_col,
  output logic [15:0] sobel_row
);

  localparam int AW = $clog2(LINE_WIDTH);

  // Raster position of the next accepted pixel.
  logic [15:0] r_col, r_row;
  // Line storage: r_lb1 holds row r-1 and r_lb2 holds row r-2, indexed by column.
  logic [11:0] r_lb1 [0:LINE_WIDTH-1];
  logic [11:0] r_lb2 [0:LINE_WIDTH-1];
  // Window row 0 = top (r-2), row 2 = bottom (r); column 0 = left (c-2), column 2 = right (c).
  logic [11:0] r_win [0:2][0:2];
  logic        r_win_valid;
  logic [15:0] r_win_col, r_win_row;
  // Stage 1: gradient magnitude and the threshold sampled alongside it.
  logic [15:0] r_mag;
  logic [11:0] r_thr;
  logic        r_s1_valid;
  logic [15:0] r_s1_col, r_s1_row;

  // A sof pixel is forced to (0,0) no matter where the counters are.
  logic [15:0] w_col, w_row;
  logic [AW-1:0] w_addr;
  logic [11:0] w_lb1, w_lb2;
  logic        w_win_ok;
  assign w_col    = sof ? 16'd0 : r_col;
  assign w_row    = sof ? 16'd0 : r_row;
  assign w_addr   = w_col[AW-1:0];
  assign w_lb1    = r_lb1[w_addr];
  assign w_lb2    = r_lb2[w_addr];
  assign w_win_ok = gray_pixel_valid && (w_row >= 16'd2) && (w_col >= 16'd2);

  // Column and row counters advance only on accepted pixels and wrap at the raster edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= 16'd0;
      r_row <= 16'd0;
    end else if (gray_pixel_valid) begin
      if (w_col == 16'(LINE_WIDTH - 1)) begin
        r_col <= 16'd0;
        r_row <= (w_row == 16'(FRAME_HEIGHT - 1)) ? 16'd0 : w_row + 16'd1;
      end else begin
        r_col <= w_col + 16'd1;
        r_row <= w_row;
      end
    end
  end

  // Line buffers are not reset; the r>=2 gate keeps stale rows out of the output.
  always_ff @(posedge clk) begin
    if (gray_pixel_valid) begin
      r_lb1[w_addr] <= gray_pixel;
      r_lb2[w_addr] <= w_lb1;
    end
  end

  // Shift a new column into the window on each accepted pixel. The valid pulse lasts one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          r_win[i][j] <= 12'd0;
      r_win_valid <= 1'b0;
      r_win_col   <= 16'd0;
      r_win_row   <= 16'd0;
    end else begin
      r_win_valid <= w_win_ok;
      if (gray_pixel_valid) begin
        for (int i = 0; i < 3; i++) begin
          r_win[i][0] <= r_win[i][1];
          r_win[i][1] <= r_win[i][2];
        end
        r_win[0][2] <= w_lb2;
        r_win[1][2] <= w_lb1;
        r_win[2][2] <= gray_pixel;
        r_win_col   <= w_col - 16'd1;
        r_win_row   <= w_row - 16'd1;
      end
    end
  end

  // Weighted 1-2-1 sums reach at most 4*4095 and fit in 14 bits, so the differences fit in 15 signed bits.
  logic [13:0] w_right, w_left, w_bottom, w_top;
  logic signed [14:0] w_gx, w_gy;
  logic [14:0] w_ax, w_ay;
  logic [15:0] w_mag;
  assign w_right  = {2'b00, r_win[0][2]} + {1'b0, r_win[1][2], 1'b0} + {2'b00, r_win[2][2]};
  assign w_left   = {2'b00, r_win[0][0]} + {1'b0, r_win[1][0], 1'b0} + {2'b00, r_win[2][0]};
  assign w_bottom = {2'b00, r_win[2][0]} + {1'b0, r_win[2][1], 1'b0} + {2'b00, r_win[2][2]};
  assign w_top    = {2'b00, r_win[0][0]} + {1'b0, r_win[0][1], 1'b0} + {2'b00, r_win[0][2]};
  assign w_gx     = $signed({1'b0, w_right})  - $signed({1'b0, w_left});
  assign w_gy     = $signed({1'b0, w_bottom}) - $signed({1'b0, w_top});
  assign w_ax     = w_gx[14] ? $unsigned(-w_gx) : $unsigned(w_gx);
  assign w_ay     = w_gy[14] ? $unsigned(-w_gy) : $unsigned(w_gy);
  assign w_mag    = {1'b0, w_ax} + {1'b0, w_ay};

  // Stage 1 registers the magnitude every clock, independent of input gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mag      <= 16'd0;
      r_thr      <= 12'd0;
      r_s1_valid <= 1'b0;
      r_s1_col   <= 16'd0;
      r_s1_row   <= 16'd0;
    end else begin
      r_mag      <= w_mag;
      r_thr      <= threshold;
      r_s1_valid <= r_win_valid;
      r_s1_col   <= r_win_col;
      r_s1_row   <= r_win_row;
    end
  end

  logic [11:0] w_sat;
  assign w_sat = (r_mag > 16'd4095) ? 12'hFFF : r_mag[11:0];

  // Stage 2 registers the saturated pixel, the edge decision and the output coordinates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sobel_pixel <= 12'd0;
      sobel_valid <= 1'b0;
      sobel_edge  <= 1'b0;
      sobel_col   <= 16'd0;
      sobel_row   <= 16'd0;
    end else begin
      sobel_pixel <= w_sat;
      sobel_valid <= r_s1_valid;
      sobel_edge  <= (w_sat >= r_thr);
      sobel_col   <= r_s1_col;
      sobel_row   <= r_s1_row;
    end
  end

endmodule

// File: tb/tb_sobel_filter.sv
// tb_sobel_filter: scoreboard bench for sobel_filter on a small 16x8 raster.
module tb_sobel_filter;

  localparam int LW = 16;
  localparam int FH = 8;
  localparam int NOUT = (LW - 2) * (FH - 2);
  localparam int W = 77;  // {cycle 32, row 16, col 16, pixel 12, edge 1}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] gray_pixel = 12'd0;
  logic        gray_pixel_valid = 1'b0;
  logic        sof = 1'b0;
  logic [11:0] threshold = 12'd0;
  logic [11:0] sobel_pixel;
  logic        sobel_valid;
  logic        sobel_edge;
  logic [15:0] sobel_col;
  logic [15:0] sobel_row;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  int img [0:FH-1][0:LW-1];
  int m_row = 0, m_col = 0;
  int n_obs, n_nonzero, n_4000, n_4095, n_edge, first_row, first_col;

  sobel_filter #(.LINE_WIDTH(LW), .FRAME_HEIGHT(FH)) dut (
    .clk(clk), .rst(rst), .gray_pixel(gray_pixel), .gray_pixel_valid(gray_pixel_valid),
    .sof(sof), .threshold(threshold), .sobel_pixel(sobel_pixel), .sobel_valid(sobel_valid),
    .sobel_edge(sobel_edge), .sobel_col(sobel_col), .sobel_row(sobel_row)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      while (exp_q.size() > 0 && int'(exp_q[0][76:45]) < cyc) begin
        checks++; failures++;
        $display("FAIL missed_output: no strobe at cycle %0d, required 0x%h", cyc, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (sobel_valid) begin
        logic [W-1:0] got, e;
        got = {32'(cyc), sobel_row, sobel_col, sobel_pixel, sobel_edge};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL spurious_strobe: got 0x%h, required no strobe", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL output: got cyc=%0d row=%0d col=%0d pix=%0d edge=%0b, required cyc=%0d row=%0d col=%0d pix=%0d edge=%0b",
                     cyc, sobel_row, sobel_col, sobel_pixel, sobel_edge,
                     e[76:45], e[44:29], e[28:13], e[12:1], e[0]);
          end
        end
        if (n_obs == 0) begin first_row = sobel_row; first_col = sobel_col; end
        n_obs++;
        if (sobel_pixel != 0) n_nonzero++;
        if (sobel_pixel == 12'd4000) n_4000++;
        if (sobel_pixel == 12'd4095) n_4095++;
        if (sobel_edge) n_edge++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    n_obs = 0; n_nonzero = 0; n_4000 = 0; n_4095 = 0; n_edge = 0;
    first_row = -1; first_col = -1;
  endtask

  // Drive one pixel at a negedge; the model predicts the result 2 clocks after the accepting edge.
  task automatic send(input logic [11:0] p, input logic s);
    int gx, gy, mag, sat;
    gray_pixel = p; gray_pixel_valid = 1'b1; sof = s;
    if (s) begin m_row = 0; m_col = 0; end
    img[m_row][m_col] = int'(p);
    if (m_row >= 2 && m_col >= 2) begin
      gx = (img[m_row-2][m_col] + 2*img[m_row-1][m_col] + img[m_row][m_col])
         - (img[m_row-2][m_col-2] + 2*img[m_row-1][m_col-2] + img[m_row][m_col-2]);
      gy = (img[m_row][m_col-2] + 2*img[m_row][m_col-1] + img[m_row][m_col])
         - (img[m_row-2][m_col-2] + 2*img[m_row-2][m_col-1] + img[m_row-2][m_col]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      sat = (mag > 4095) ? 4095 : mag;
      exp_q.push_back({32'(cyc + 3), 16'(m_row - 1), 16'(m_col - 1), 12'(sat),
                       (sat >= int'(threshold))});
    end
    if (m_col == LW - 1) begin
      m_col = 0;
      m_row = (m_row == FH - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
    @(negedge clk);
    gray_pixel_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic idle(input int n);
    gray_pixel_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [11:0] gen(input int mode, input int r, input int c);
    case (mode)
      0: return 12'd1234;
      1: return (c >= LW/2) ? 12'd1000 : 12'd0;
      2: return (c >= LW/2) ? 12'd2000 : 12'd0;
      3: return (r >= FH/2) ? 12'd1000 : 12'd0;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  task automatic run_frame(input int mode, input bit gaps);
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < LW; c++) begin
        send(gen(mode, r, c), 1'b0);
        if (gaps) idle($urandom_range(0, 3));
      end
  endtask

  // Bounded wait for all predicted outputs to appear.
  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d outputs outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    idle(2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (sobel_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", sobel_valid); end
    checks++; if (sobel_pixel !== 12'd0) begin failures++; $display("FAIL reset_pixel: got %0d required 0", sobel_pixel); end
    checks++; if (sobel_col !== 16'd0) begin failures++; $display("FAIL reset_col: got %0d required 0", sobel_col); end
    checks++; if (sobel_row !== 16'd0) begin failures++; $display("FAIL reset_row: got %0d required 0", sobel_row); end
    rst = 1'b0;
    m_row = 0; m_col = 0;
    idle(2);
  endtask

  task automatic test_constant();
    threshold = 12'd1; clear_stats();
    run_frame(0, 1'b0); drain();
    checks++; if (n_obs != NOUT) begin failures++; $display("FAIL const_count: got %0d required %0d", n_obs, NOUT); end
    checks++; if (n_nonzero != 0) begin failures++; $display("FAIL const_nonzero: got %0d required 0", n_nonzero); end
    checks++; if (n_edge != 0) begin failures++; $display("FAIL const_edge: got %0d required 0", n_edge); end
    checks++; if (first_row != 1 || first_col != 1) begin failures++; $display("FAIL const_first: got (%0d,%0d) required (1,1)", first_row, first_col); end
  endtask

  task automatic test_vertical_step();
    threshold = 12'd3000; clear_stats();
    run_frame(1, 1'b0); drain();
    checks++; if (n_4000 != 2*(FH-2)) begin failures++; $display("FAIL vstep_4000: got %0d required %0d", n_4000, 2*(FH-2)); end
    checks++; if (n_nonzero != 2*(FH-2)) begin failures++; $display("FAIL vstep_nonzero: got %0d required %0d", n_nonzero, 2*(FH-2)); end
    checks++; if (n_edge != 2*(FH-2)) begin failures++; $display("FAIL vstep_edge: got %0d required %0d", n_edge, 2*(FH-2)); end
  endtask

  task automatic test_saturate();
    threshold = 12'd3000; clear_stats();
    run_frame(2, 1'b0); drain();
    checks++; if (n_4095 != 2*(FH-2)) begin failures++; $display("FAIL sat_4095: got %0d required %0d", n_4095, 2*(FH-2)); end
    checks++; if (n_nonzero != 2*(FH-2)) begin failures++; $display("FAIL sat_nonzero: got %0d required %0d", n_nonzero, 2*(FH-2)); end
  endtask

  task automatic test_horizontal_step();
    threshold = 12'd3000; clear_stats();
    run_frame(3, 1'b0); drain();
    checks++; if (n_4000 != 2*(LW-2)) begin failures++; $display("FAIL hstep_4000: got %0d required %0d", n_4000, 2*(LW-2)); end
    checks++; if (n_nonzero != 2*(LW-2)) begin failures++; $display("FAIL hstep_nonzero: got %0d required %0d", n_nonzero, 2*(LW-2)); end
  endtask

  task automatic test_gaps();
    threshold = 12'd2048; clear_stats();
    run_frame(4, 1'b1); drain();
    checks++; if (n_obs != NOUT) begin failures++; $display("FAIL gaps_count: got %0d required %0d", n_obs, NOUT); end
  endtask

  task automatic test_back_to_back();
    threshold = 12'd1500; clear_stats();
    run_frame(4, 1'b0); run_frame(4, 1'b0); drain();
    checks++; if (n_obs != 2*NOUT) begin failures++; $display("FAIL b2b_count: got %0d required %0d", n_obs, 2*NOUT); end
  endtask

  task automatic test_sof();
    threshold = 12'd1000;
    for (int i = 0; i < 5*LW + 3; i++) send(gen(4, 0, 0), 1'b0);
    drain(); clear_stats();
    send(gen(4, 0, 0), 1'b1);
    for (int i = 1; i < LW*FH; i++) send(gen(4, 0, 0), 1'b0);
    drain();
    checks++; if (n_obs != NOUT) begin failures++; $display("FAIL sof_count: got %0d required %0d", n_obs, NOUT); end
    checks++; if (first_row != 1 || first_col != 1) begin failures++; $display("FAIL sof_first: got (%0d,%0d) required (1,1)", first_row, first_col); end
  endtask

  task automatic test_reset_mid();
    threshold = 12'd1000;
    for (int i = 0; i < 5*LW + 6; i++) send(gen(4, 0, 0), 1'b0);
    send(gen(4, 0, 0), 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    checks++; if (sobel_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b required 0", sobel_valid); end
    checks++; if (sobel_pixel !== 12'd0) begin failures++; $display("FAIL midrst_pixel: got %0d required 0", sobel_pixel); end
    checks++; if (sobel_col !== 16'd0 || sobel_row !== 16'd0) begin failures++; $display("FAIL midrst_pos: got (%0d,%0d) required (0,0)", sobel_row, sobel_col); end
    exp_q.delete();
    m_row = 0; m_col = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    clear_stats();
    run_frame(4, 1'b0); drain();
    checks++; if (n_obs != NOUT) begin failures++; $display("FAIL midrst_count: got %0d required %0d", n_obs, NOUT); end
    checks++; if (first_row != 1 || first_col != 1) begin failures++; $display("FAIL midrst_first: got (%0d,%0d) required (1,1)", first_row, first_col); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_stats();
    test_reset();
    test_constant();
    test_vertical_step();
    test_saturate();
    test_horizontal_step();
    test_gaps();
    test_back_to_back();
    test_sof();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
